issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Centralized reservation-station issue queue for the Tomasulo RV32 core.
- Sits between dispatch/rename and the functional units.
- Holds dispatched micro-ops until both source operands are captured from dispatch or from the CDB, then issues one ready entry per cycle to the FU.
- Supports full pipeline flush on branch mispredict or exception.

Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- TAG_W, 5, ROB tag width
- DATA_W, 32, operand width
- OP_W, 6, opcode/function field width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all entries
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept dispatch
- disp_op  in  OP_W  micro-op
- disp_dest_tag  in  TAG_W  destination ROB tag
- disp_src1_rdy / disp_src2_rdy  in  1  operand value already known
- disp_src1_tag / disp_src2_tag  in  TAG_W  producer tag when not ready
- disp_src1_val / disp_src2_val  in  DATA_W  operand value when ready
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  DATA_W  broadcast value
- issue_valid  out  1  selected entry presented to FU
- issue_ready  in  1  FU accepts
- issue_op  out  OP_W
- issue_dest_tag  out  TAG_W
- issue_src1_val / issue_src2_val  out  DATA_W
- empty  out  1  no valid entries
- full  out  1  all entries valid
- count  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (rst=0, async): all valid bits cleared; count=0, empty=1, full=0, issue_valid=0. Entry payloads are don't-care.
- Dispatch: accepted when disp_valid && disp_ready.
  - disp_ready = !full && !flush.
  - The entry is written into the lowest-index free slot on the rising edge.
- Dispatch wakeup bypass: if a source is not ready and cdb_valid && cdb_tag == src tag in the same cycle, the entry is written with that source ready and value = cdb_value.
- CDB wakeup: every valid entry with a waiting source whose tag matches cdb_tag (cdb_valid=1) captures cdb_value and sets its ready bit at the edge. Both sources may wake on the same broadcast.
- Ready condition: valid && src1_rdy && src2_rdy, evaluated on registered state. An entry woken at edge N can issue in the cycle after edge N, never earlier.
- Select: lowest-index ready entry. issue_* outputs are combinational from that entry; issue_valid = any ready && !flush.
- Issue handshake: on issue_valid && issue_ready, the entry's valid bit clears at the edge. Outputs must hold stable while issue_valid=1 and issue_ready=0, unless a lower-index entry becomes ready.
- Simultaneous dispatch and issue:
  - Both occur; count unchanged.
  - The freed slot is not reused in the same cycle.
  - When full, disp_ready=0 even if an issue happens that cycle.
- Flush: at the edge with flush=1, all valid bits clear; dispatch and issue are suppressed that cycle. empty=1 from the following cycle. Flush has priority over dispatch, wakeup and issue.
- Status: count = popcount(valid); empty = (count==0); full = (count==DEPTH). All are registered-state derived.

Optional Feature:
- Macro ISSUE_QUEUE_PERF_EN.
- Defined: adds outputs perf_full_cycles[31:0] (increments each cycle full=1 and disp_valid=1) and perf_issued[31:0] (increments per accepted issue). Both are cleared by reset, not by flush, and saturate at all-ones.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package tomasulo_pkg holds: TAG_W, DATA_W and OP_W constants; typedef iq_entry_t (valid, op, dest_tag, src1/src2 rdy, tag, val); typedef tag_t.
- Sub-module iq_select: DEPTH-bit request vector in; one-hot grant plus index and any-valid out, with lowest-index priority. It is reused for free-slot allocation as a second instance.

Test Plan:
- Reset: rst=0 for 1 cycle, then 1 -> empty=1, full=0, count=0, issue_valid=0.
- Dispatch op=0x01, dest=3, both sources ready (val 10, 20) -> next cycle issue_valid=1, issue_src1_val=10, issue_src2_val=20; with issue_ready=1, empty=1 after the edge.
- Dispatch dest=4 with src1 waiting on tag 7 -> issue_valid=0; cdb_valid=1, tag=7, value=0xDEAD -> issue_valid=1 the next cycle, issue_src1_val=0xDEAD.
- Fill 8 ready entries with issue_ready=0 -> full=1, disp_ready=0, count=8. A 9th dispatch is ignored; issue order is slots 0..7.
- Dispatch with src2 tag 9 while cdb_tag=9 in the same cycle -> entry captured ready, issues the next cycle.
- Load 3 entries, assert flush=1 for one cycle with disp_valid=1 -> after the edge empty=1, count=0, issue_valid=0, and the dispatched op is not stored.

Source files
------------

// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tomasulo_pkg
// Description : Shared widths and types for the Tomasulo RV32 core. Holds
//               the ROB tag, operand and opcode widths, the tag type, and the
//               issue-queue entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

   localparam int TAG_W  = 5;
   localparam int DATA_W = 32;
   localparam int OP_W   = 6;

   typedef logic [TAG_W-1:0] tag_t;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   op;
      tag_t              dest_tag;
      logic              src1_rdy;
      tag_t              src1_tag;
      logic [DATA_W-1:0] src1_val;
      logic              src2_rdy;
      tag_t              src2_tag;
      logic [DATA_W-1:0] src2_val;
   } iq_entry_t;

endpackage : tomasulo_pkg
`default_nettype wire

// File: rtl/iq_select.sv
`default_nettype none
// ============================================================================
// Module      : iq_select
// Description : Lowest-index priority picker. Used by the issue queue both
//               to choose the entry to issue and to find a free slot.
// Ports       : i_req   - N-bit request vector
//               o_grant - one-hot grant of the lowest set request bit
//               o_idx   - binary index of the granted bit (0 when none)
//               o_any   - at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module iq_select #(
   parameter int N     = 8,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = |i_req;
      // Scan from the top down so the lowest set bit is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IDX_W'(i);
      end
      if (o_any) o_grant[o_idx] = 1'b1;
   end

endmodule : iq_select
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : issue_queue
// Description : Centralised reservation-station issue queue. Holds dispatched
//               micro-ops until both operands are known (at dispatch or via
//               CDB wakeup), then issues the lowest-index ready entry, one per
//               cycle. A synchronous flush discards all entries.
// Ports       : clk, rst (async, active-low), flush
//               disp_*  - dispatch handshake and micro-op payload
//               cdb_*   - result broadcast for operand wakeup
//               issue_* - issue handshake and selected payload to the FU
//               empty / full / count - occupancy status
// Options     : ISSUE_QUEUE_PERF_EN adds perf_full_cycles and perf_issued
//               saturating counters (cleared only by reset).
// Revision    : 1.0 - initial release
// ============================================================================
module issue_queue
   import tomasulo_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int TAG_W  = tomasulo_pkg::TAG_W,
   parameter int DATA_W = tomasulo_pkg::DATA_W,
   parameter int OP_W   = tomasulo_pkg::OP_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   disp_valid,
   output logic                   disp_ready,
   input  logic [OP_W-1:0]        disp_op,
   input  logic [TAG_W-1:0]       disp_dest_tag,
   input  logic                   disp_src1_rdy,
   input  logic                   disp_src2_rdy,
   input  logic [TAG_W-1:0]       disp_src1_tag,
   input  logic [TAG_W-1:0]       disp_src2_tag,
   input  logic [DATA_W-1:0]      disp_src1_val,
   input  logic [DATA_W-1:0]      disp_src2_val,
   input  logic                   cdb_valid,
   input  logic [TAG_W-1:0]       cdb_tag,
   input  logic [DATA_W-1:0]      cdb_value,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [OP_W-1:0]        issue_op,
   output logic [TAG_W-1:0]       issue_dest_tag,
   output logic [DATA_W-1:0]      issue_src1_val,
   output logic [DATA_W-1:0]      issue_src2_val,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
`ifdef ISSUE_QUEUE_PERF_EN
   ,
   output logic [31:0]            perf_full_cycles,
   output logic [31:0]            perf_issued
`endif
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH) + 1;

   iq_entry_t r_ent [DEPTH];

   logic [DEPTH-1:0]   w_valid_vec;
   logic [DEPTH-1:0]   w_rdy_vec;
   logic [DEPTH-1:0]   w_iss_grant;
   logic [c_IDX_W-1:0] w_iss_idx;
   logic               w_iss_any;
   logic [DEPTH-1:0]   w_free_grant;
   logic [c_IDX_W-1:0] w_free_idx_unused;
   logic               w_free_any;
   logic [c_CNT_W-1:0] w_count;
   logic               w_disp_fire;
   logic               w_issue_fire;
   iq_entry_t          w_new_ent;

   always_comb begin
      w_valid_vec = '0;
      w_rdy_vec   = '0;
      w_count     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_valid_vec[i] = r_ent[i].valid;
         w_rdy_vec[i]   = r_ent[i].valid & r_ent[i].src1_rdy & r_ent[i].src2_rdy;
         w_count        = w_count + c_CNT_W'(r_ent[i].valid);
      end
   end

   iq_select #(.N(DEPTH)) u_issue_sel (
      .i_req   (w_rdy_vec),
      .o_grant (w_iss_grant),
      .o_idx   (w_iss_idx),
      .o_any   (w_iss_any)
   );

   // Free-slot search runs on registered valid bits, so a slot emptied by
   // issue this cycle is only reusable from the next cycle on.
   iq_select #(.N(DEPTH)) u_free_sel (
      .i_req   (~w_valid_vec),
      .o_grant (w_free_grant),
      .o_idx   (w_free_idx_unused),
      .o_any   (w_free_any)
   );

   assign count      = w_count;
   assign empty      = (w_count == '0);
   assign full       = (w_count == c_CNT_W'(DEPTH));
   // A free slot exists exactly when the queue is not full.
   assign disp_ready = w_free_any & ~flush;
   assign w_disp_fire  = disp_valid & disp_ready;

   assign issue_valid    = w_iss_any & ~flush;
   assign w_issue_fire   = issue_valid & issue_ready;
   assign issue_op       = r_ent[w_iss_idx].op;
   assign issue_dest_tag = r_ent[w_iss_idx].dest_tag;
   assign issue_src1_val = r_ent[w_iss_idx].src1_val;
   assign issue_src2_val = r_ent[w_iss_idx].src2_val;

   // New entry, with a same-cycle CDB match bypassed straight into it.
   always_comb begin
      w_new_ent          = '0;
      w_new_ent.valid    = 1'b1;
      w_new_ent.op       = disp_op;
      w_new_ent.dest_tag = disp_dest_tag;
      w_new_ent.src1_rdy = disp_src1_rdy;
      w_new_ent.src1_tag = disp_src1_tag;
      w_new_ent.src1_val = disp_src1_val;
      w_new_ent.src2_rdy = disp_src2_rdy;
      w_new_ent.src2_tag = disp_src2_tag;
      w_new_ent.src2_val = disp_src2_val;
      if (!disp_src1_rdy && cdb_valid && (cdb_tag == disp_src1_tag)) begin
         w_new_ent.src1_rdy = 1'b1;
         w_new_ent.src1_val = cdb_value;
      end
      if (!disp_src2_rdy && cdb_valid && (cdb_tag == disp_src2_tag)) begin
         w_new_ent.src2_rdy = 1'b1;
         w_new_ent.src2_val = cdb_value;
      end
   end

   // Payloads are left unreset; only valid bits matter after reset/flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].valid && cdb_valid) begin
               if (!r_ent[i].src1_rdy && (r_ent[i].src1_tag == cdb_tag)) begin
                  r_ent[i].src1_rdy <= 1'b1;
                  r_ent[i].src1_val <= cdb_value;
               end
               if (!r_ent[i].src2_rdy && (r_ent[i].src2_tag == cdb_tag)) begin
                  r_ent[i].src2_rdy <= 1'b1;
                  r_ent[i].src2_val <= cdb_value;
               end
            end
            if (w_issue_fire && w_iss_grant[i]) r_ent[i].valid <= 1'b0;
            // The dispatch target is an invalid slot, so it never collides
            // with the wakeup or issue updates above.
            if (w_disp_fire && w_free_grant[i]) r_ent[i] <= w_new_ent;
         end
      end
   end

`ifdef ISSUE_QUEUE_PERF_EN
   logic [31:0] r_perf_full_cycles;
   logic [31:0] r_perf_issued;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_full_cycles <= '0;
         r_perf_issued      <= '0;
      end else begin
         if (full && disp_valid && (r_perf_full_cycles != '1))
            r_perf_full_cycles <= r_perf_full_cycles + 32'd1;
         if (w_issue_fire && (r_perf_issued != '1))
            r_perf_issued <= r_perf_issued + 32'd1;
      end
   end

   assign perf_full_cycles = r_perf_full_cycles;
   assign perf_issued      = r_perf_issued;
`else
   // Performance counters not built.
`endif

endmodule : issue_queue
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_queue
// Description : Directed self-checking bench for issue_queue. Expected issue
//               payloads are queued when a dispatch is driven and compared
//               whenever the queue hands an entry to the FU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic [5:0]  disp_op;
   logic [4:0]  disp_dest_tag;
   logic        disp_src1_rdy, disp_src2_rdy;
   logic [4:0]  disp_src1_tag, disp_src2_tag;
   logic [31:0] disp_src1_val, disp_src2_val;
   logic        cdb_valid;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        issue_valid;
   logic        issue_ready;
   logic [5:0]  issue_op;
   logic [4:0]  issue_dest_tag;
   logic [31:0] issue_src1_val, issue_src2_val;
   logic        empty, full;
   logic [3:0]  count;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  dest;
      logic [31:0] s1;
      logic [31:0] s2;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   issue_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_op        (disp_op),
      .disp_dest_tag  (disp_dest_tag),
      .disp_src1_rdy  (disp_src1_rdy),
      .disp_src2_rdy  (disp_src2_rdy),
      .disp_src1_tag  (disp_src1_tag),
      .disp_src2_tag  (disp_src2_tag),
      .disp_src1_val  (disp_src1_val),
      .disp_src2_val  (disp_src2_val),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_value      (cdb_value),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_op       (issue_op),
      .issue_dest_tag (issue_dest_tag),
      .issue_src1_val (issue_src1_val),
      .issue_src2_val (issue_src2_val),
      .empty          (empty),
      .full           (full),
      .count          (count)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic drive_disp(input logic [5:0] op, input logic [4:0] dest,
                             input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                             input logic r2, input logic [4:0] t2, input logic [31:0] v2);
      disp_valid    = 1'b1;
      disp_op       = op;
      disp_dest_tag = dest;
      disp_src1_rdy = r1;
      disp_src1_tag = t1;
      disp_src1_val = v1;
      disp_src2_rdy = r2;
      disp_src2_tag = t2;
      disp_src2_val = v2;
   endtask

   task automatic push(input logic [5:0] op, input logic [4:0] dest,
                       input logic [31:0] s1, input logic [31:0] s2);
      exp_t e;
      e.op = op; e.dest = dest; e.s1 = s1; e.s2 = s2;
      sb.push_back(e);
   endtask

   // One clock: score any handshake presented this cycle, then advance.
   task automatic cycle();
      exp_t e;
      #1;
      if (issue_valid && issue_ready) begin
         if (sb.size() == 0) begin
            check("spurious_issue", 64'(1), 64'(0));
         end else begin
            e = sb.pop_front();
            check("iss_op",   64'(issue_op),       64'(e.op));
            check("iss_dest", 64'(issue_dest_tag), 64'(e.dest));
            check("iss_src1", 64'(issue_src1_val), 64'(e.s1));
            check("iss_src2", 64'(issue_src2_val), 64'(e.s2));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0;
      disp_op = '0; disp_dest_tag = '0; disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
      disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_val = '0; disp_src2_val = '0;
      cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_empty", 64'(empty), 64'(1));
      check("rst_full",  64'(full),  64'(0));
      check("rst_count", 64'(count), 64'(0));
      check("rst_ivld",  64'(issue_valid), 64'(0));
      check("rst_drdy",  64'(disp_ready),  64'(1));

      // Both operands ready at dispatch.
      drive_disp(6'h01, 5'd3, 1'b1, 5'd0, 32'd10, 1'b1, 5'd0, 32'd20);
      push(6'h01, 5'd3, 32'd10, 32'd20);
      cycle();
      disp_valid = 1'b0; #1;
      check("t2_ivld",  64'(issue_valid),    64'(1));
      check("t2_src1",  64'(issue_src1_val), 64'(10));
      check("t2_src2",  64'(issue_src2_val), 64'(20));
      check("t2_count", 64'(count),          64'(1));
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0; #1;
      check("t2_empty", 64'(empty), 64'(1));

      // src1 waits on tag 7, woken by a later broadcast.
      drive_disp(6'h02, 5'd4, 1'b0, 5'd7, 32'd0, 1'b1, 5'd0, 32'd5);
      push(6'h02, 5'd4, 32'hDEAD, 32'd5);
      cycle();
      disp_valid = 1'b0; #1;
      check("t3_wait_ivld", 64'(issue_valid), 64'(0));
      cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_value = 32'hDEAD; #1;
      check("t3_no_early",  64'(issue_valid), 64'(0));
      cycle();
      cdb_valid = 1'b0; #1;
      check("t3_ivld", 64'(issue_valid),    64'(1));
      check("t3_src1", 64'(issue_src1_val), 64'(32'hDEAD));
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;

      // Both sources wait on the same tag and wake on one broadcast.
      drive_disp(6'h03, 5'd5, 1'b0, 5'd11, 32'd0, 1'b0, 5'd11, 32'd0);
      push(6'h03, 5'd5, 32'h77, 32'h77);
      cycle();
      disp_valid = 1'b0;
      cdb_valid = 1'b1; cdb_tag = 5'd11; cdb_value = 32'h77;
      cycle();
      cdb_valid = 1'b0; #1;
      check("both_wake_ivld", 64'(issue_valid), 64'(1));
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;

      // Fill all slots, then try a ninth dispatch.
      for (int i = 0; i < DEPTH; i++) begin
         drive_disp(6'(6'h10 + i), 5'(i), 1'b1, 5'd0, 32'(i * 3), 1'b1, 5'd0, 32'(i * 3 + 1));
         push(6'(6'h10 + i), 5'(i), 32'(i * 3), 32'(i * 3 + 1));
         cycle();
      end
      disp_valid = 1'b0; #1;
      check("fill_full",  64'(full),       64'(1));
      check("fill_drdy",  64'(disp_ready), 64'(0));
      check("fill_count", 64'(count),      64'(8));
      drive_disp(6'h3F, 5'd31, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
      cycle();
      disp_valid = 1'b0; #1;
      check("ninth_count", 64'(count), 64'(8));
      // Full queue refuses dispatch even while an issue frees a slot.
      drive_disp(6'h3E, 5'd30, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0, 32'd2);
      issue_ready = 1'b1; #1;
      check("full_issue_drdy", 64'(disp_ready), 64'(0));
      cycle();
      disp_valid = 1'b0;
      for (int i = 1; i < DEPTH; i++) cycle();
      issue_ready = 1'b0; #1;
      check("drain_empty", 64'(empty), 64'(1));

      // Dispatch and issue in the same cycle keep count unchanged.
      drive_disp(6'h21, 5'd12, 1'b1, 5'd0, 32'd100, 1'b1, 5'd0, 32'd200);
      push(6'h21, 5'd12, 32'd100, 32'd200);
      cycle();
      drive_disp(6'h22, 5'd13, 1'b1, 5'd0, 32'd300, 1'b1, 5'd0, 32'd400);
      push(6'h22, 5'd13, 32'd300, 32'd400);
      issue_ready = 1'b1; #1;
      check("simul_drdy", 64'(disp_ready), 64'(1));
      cycle();
      disp_valid = 1'b0; issue_ready = 1'b0; #1;
      check("simul_count", 64'(count), 64'(1));
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;

      // Dispatch-time CDB bypass on src2.
      drive_disp(6'h05, 5'd6, 1'b1, 5'd0, 32'd1, 1'b0, 5'd9, 32'd0);
      cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_value = 32'hBEEF;
      push(6'h05, 5'd6, 32'd1, 32'hBEEF);
      cycle();
      disp_valid = 1'b0; cdb_valid = 1'b0; #1;
      check("bypass_ivld", 64'(issue_valid), 64'(1));
      issue_ready = 1'b1;
      cycle();
      issue_ready = 1'b0;

      // Flush with three entries loaded and a dispatch pending.
      for (int i = 0; i < 3; i++) begin
         drive_disp(6'(6'h30 + i), 5'(20 + i), 1'b1, 5'd0, 32'(i), 1'b1, 5'd0, 32'(i));
         push(6'(6'h30 + i), 5'(20 + i), 32'(i), 32'(i));
         cycle();
      end
      drive_disp(6'h2A, 5'd27, 1'b1, 5'd0, 32'd9, 1'b1, 5'd0, 32'd9);
      flush = 1'b1; issue_ready = 1'b1; #1;
      check("flush_ivld", 64'(issue_valid), 64'(0));
      check("flush_drdy", 64'(disp_ready),  64'(0));
      cycle();
      sb.delete();
      flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0; #1;
      check("post_flush_empty", 64'(empty), 64'(1));
      check("post_flush_count", 64'(count), 64'(0));
      check("post_flush_ivld",  64'(issue_valid), 64'(0));
      cycle();
      check("post_flush_ivld2", 64'(issue_valid), 64'(0));
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_issue_queue
`default_nettype wire
